// File: rtl/tff_ctrl_pkg.sv
// Shared types and constants for the T-FF counter controller.
package tff_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop: q inverts on each rising edge where t is high.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= 1'b0;
    else if (t)
      q <= ~q;
  end

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequences a bank of T flip-flops as a programmable counter with one-shot or
// auto-reload periods, a done pulse and a divided square wave at terminal count.
module tff_count_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] period,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count,
  output logic             tc_toggle
);

  state_t           state, state_next;
  logic [WIDTH-1:0] period_q, period_next;
  logic             mode_q, mode_next;
  logic             done_next;
  logic             tc_hit;
  logic             tc_strobe;
  logic [WIDTH-1:0] t_inc;
  logic [WIDTH-1:0] t;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      period_q <= '0;
      mode_q   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      period_q <= period_next;
      mode_q   <= mode_next;
      done     <= done_next;
    end
  end

  // Ripple-carry enables: bit i toggles when every lower bit is set.
  always_comb begin
    t_inc[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++)
      t_inc[i] = t_inc[i-1] & count[i-1];
  end

  assign tc_hit    = (state == RUN) && (count == period_q);
  assign tc_strobe = tc_hit && !stop;

  // The bank is never loaded; clearing toggles exactly the bits that are set.
  always_comb begin
    state_next  = state;
    period_next = period_q;
    mode_next   = mode_q;
    done_next   = 1'b0;
    t           = count;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          period_next = period;
          mode_next   = auto_reload;
          state_next  = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (tc_hit) begin
          done_next = 1'b1;
          if (mode_q)
            period_next = period;
          else
            state_next = IDLE;
        end else begin
          t = t_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t[i]),
      .q   (count[i])
    );
  end

  tff_cell u_tc_cell (
    .clk (clk),
    .rst (rst),
    .t   (tc_strobe),
    .q   (tc_toggle)
  );

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Scoreboard bench: a behavioural model pushes expected outputs per cycle,
// which are popped and compared just after each rising edge.
module tb_tff_count_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       auto_reload;
  logic [7:0] period;
  logic       busy;
  logic       done;
  logic [7:0] count;
  logic       tc_toggle;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] count;
    logic       tc;
  } exp_t;

  exp_t expQueue[$];

  int checkCount = 0;
  int passCount  = 0;
  int donePulses = 0;

  // Behavioural reference state
  logic       mRun;
  logic [7:0] mCount;
  logic [7:0] mPeriod;
  logic       mMode;
  logic       mDone;
  logic       mTc;

  tff_count_ctrl #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .period      (period),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .tc_toggle   (tc_toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
  endtask

  task automatic modelReset();
    mRun = 1'b0; mCount = '0; mPeriod = '0; mMode = 1'b0; mDone = 1'b0; mTc = 1'b0;
  endtask

  task automatic modelStep(input logic s, input logic sp, input logic ar, input logic [7:0] p);
    mDone = 1'b0;
    if (!mRun) begin
      mCount = '0;
      if (s && !sp) begin
        mPeriod = p;
        mMode   = ar;
        mRun    = 1'b1;
      end
    end else if (sp) begin
      mRun   = 1'b0;
      mCount = '0;
    end else if (mCount == mPeriod) begin
      mDone  = 1'b1;
      mTc    = ~mTc;
      mCount = '0;
      if (mMode) mPeriod = p;
      else       mRun = 1'b0;
    end else begin
      mCount = mCount + 8'd1;
    end
  endtask

  // One clock: drive inputs, predict, wait for the edge, compare.
  task automatic applyStimulus(input logic s, input logic sp, input logic ar, input logic [7:0] p);
    exp_t e;
    start = s; stop = sp; auto_reload = ar; period = p;
    modelStep(s, sp, ar, p);
    expQueue.push_back('{busy: mRun, done: mDone, count: mCount, tc: mTc});
    @(posedge clk);
    #1;
    e = expQueue.pop_front();
    checkOutput("busy",      {31'd0, busy},      {31'd0, e.busy});
    checkOutput("done",      {31'd0, done},      {31'd0, e.done});
    checkOutput("count",     {24'd0, count},     {24'd0, e.count});
    checkOutput("tc_toggle", {31'd0, tc_toggle}, {31'd0, e.tc});
    if (done) donePulses++;
  endtask

  task automatic idleCycles(input int n, input logic [7:0] p);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, p);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; auto_reload = 1'b0; period = '0;
    modelReset();
    #12;
    checkOutput("reset_busy",  {31'd0, busy},      32'd0);
    checkOutput("reset_done",  {31'd0, done},      32'd0);
    checkOutput("reset_count", {24'd0, count},     32'd0);
    checkOutput("reset_tc",    {31'd0, tc_toggle}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] one-shot P=3");
    donePulses = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd3);
    idleCycles(6, 8'd3);
    checkOutput("oneshot_done_pulses", donePulses, 32'd1);
    checkOutput("oneshot_tc_final", {31'd0, tc_toggle}, 32'd1);

    $display("[TB] auto-reload P=2, then period 5 mid-run");
    donePulses = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd2);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'd2);
    checkOutput("auto_done_pulses", donePulses, 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd5);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'd5);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd5);

    $display("[TB] stop mid-count and on terminal count");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd4);
    idleCycles(2, 8'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd4);
    idleCycles(2, 8'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd1);
    idleCycles(2, 8'd1);

    $display("[TB] P=0 auto-reload and P=255 one-shot");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    donePulses = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd255);
    idleCycles(258, 8'd255);
    checkOutput("full_range_done_pulses", donePulses, 32'd1);

    $display("[TB] start+stop in IDLE, start during RUN");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd3);
    idleCycles(2, 8'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd6);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd1);
    idleCycles(7, 8'd1);

    $display("[TB] async reset mid-run");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd10);
    idleCycles(5, 8'd10);
    checkOutput("pre_reset_count", {24'd0, count}, 32'd5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_busy",  {31'd0, busy},      32'd0);
    checkOutput("async_done",  {31'd0, done},      32'd0);
    checkOutput("async_count", {24'd0, count},     32'd0);
    checkOutput("async_tc",    {31'd0, tc_toggle}, 32'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd4);
    idleCycles(7, 8'd4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
